// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmitter.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic SS_ACTIVE = 1'b1;
    localparam logic SCK_IDLE  = 1'b0;

    localparam int DEFAULT_FRAME_BITS = 11;

endpackage

// File: rtl/spi_master_tx_if.sv
// Word-side handshake bundle between a producer (master) and the SPI transmitter (slave).
interface spi_master_tx_if
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS
);
    logic [FRAME_BITS-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_done;
    logic                  busy;
    logic [FRAME_BITS-1:0] rx_data;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, busy, rx_data
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, busy, rx_data
    );
endinterface

// File: rtl/spi_sck_tick.sv
// sck half-period timer: tick is high in the last clk of each CLK_DIV-cycle half-period.
module spi_sck_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt_reg;

    assign tick = (div_cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (clr || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + W'(1);
        end
    end
endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter, MSB first, active-high ss.
// Optional miso capture into rx_data when SPI_MISO_CAPTURE_EN is defined.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_tx_if.slave        bus,
    output logic                  sck,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t                state_reg;
    logic [FRAME_BITS-1:0] shreg_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic [GW-1:0]         gap_cnt_reg;
    logic                  sck_reg;
    logic                  ss_reg;
    logic                  mosi_reg;
    logic                  tx_done_reg;
    logic                  busy_reg;
    logic                  tx_ready_reg;
    logic                  tick;
    logic                  accept;

    // tx_ready_reg is high exactly while in IDLE, so it doubles as the accept qualifier.
    assign accept = bus.tx_valid & tx_ready_reg;

    spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            sck_reg      <= SCK_IDLE;
            ss_reg       <= ~SS_ACTIVE;
            mosi_reg     <= 1'b0;
            tx_done_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            tx_ready_reg <= 1'b1;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shreg_reg    <= bus.tx_data;
                        bit_cnt_reg  <= '0;
                        ss_reg       <= SS_ACTIVE;
                        mosi_reg     <= bus.tx_data[FRAME_BITS-1];
                        busy_reg     <= 1'b1;
                        tx_ready_reg <= 1'b0;
                        state_reg    <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        sck_reg   <= ~SCK_IDLE;
                        state_reg <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sck_reg <= SCK_IDLE;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= TRAIL;
                        end else begin
                            // Next bit goes out on the falling edge, half a period before the slave samples it.
                            bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            shreg_reg   <= shreg_reg << 1;
                            mosi_reg    <= shreg_reg[FRAME_BITS-2];
                            state_reg   <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        sck_reg   <= ~SCK_IDLE;
                        state_reg <= HIGH;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ss_reg      <= ~SS_ACTIVE;
                        mosi_reg    <= 1'b0;
                        tx_done_reg <= 1'b1;
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        busy_reg     <= 1'b0;
                        tx_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic [FRAME_BITS-1:0] rx_sh_reg;
    logic [FRAME_BITS-1:0] rx_data_reg;

    // miso is sampled on the same edge that raises sck; the word is published with tx_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sh_reg   <= '0;
            rx_data_reg <= '0;
        end else begin
            if (tick && (state_reg == LEAD || state_reg == LOW)) begin
                rx_sh_reg <= {rx_sh_reg[FRAME_BITS-2:0], miso};
            end
            if (tick && state_reg == TRAIL) begin
                rx_data_reg <= rx_sh_reg;
            end
        end
    end

    assign bus.rx_data = rx_data_reg;
`else
    logic miso_unused;
    assign miso_unused = miso;
    assign bus.rx_data = '0;
`endif

    assign bus.tx_ready = tx_ready_reg;
    assign bus.tx_done  = tx_done_reg;
    assign bus.busy     = busy_reg;
    assign sck          = sck_reg;
    assign ss           = ss_reg;
    assign mosi         = mosi_reg;
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: CLK_DIV=2 and CLK_DIV=1 instances checked against a frame-level model.
module tb_spi_master_tx;
    localparam int F   = 11;
    localparam int GAP = 2;
`ifdef SPI_MISO_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_tx_if #(.FRAME_BITS(F)) bus_a ();
    spi_master_tx_if #(.FRAME_BITS(F)) bus_b ();

    logic sck_a, ss_a, mosi_a, miso_a;
    logic sck_b, ss_b, mosi_b, miso_b;
    int   miso_mode = 2;   // 0: loop mosi back, 1: constant 1, 2: constant 0
    bit   on_b = 1'b0;

    assign miso_a = (miso_mode == 0) ? mosi_a : (miso_mode == 1);
    assign miso_b = (miso_mode == 0) ? mosi_b : (miso_mode == 1);

    spi_master_tx #(.CLK_DIV(2), .FRAME_BITS(F), .GAP_CYCLES(GAP)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .sck(sck_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
    );
    spi_master_tx #(.CLK_DIV(1), .FRAME_BITS(F), .GAP_CYCLES(GAP)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .sck(sck_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
    );

    logic         m_sck, m_ss, m_mosi, m_done, m_ready, m_busy;
    logic [F-1:0] m_rx;
    assign m_sck   = on_b ? sck_b : sck_a;
    assign m_ss    = on_b ? ss_b : ss_a;
    assign m_mosi  = on_b ? mosi_b : mosi_a;
    assign m_done  = on_b ? bus_b.tx_done : bus_a.tx_done;
    assign m_ready = on_b ? bus_b.tx_ready : bus_a.tx_ready;
    assign m_busy  = on_b ? bus_b.busy : bus_a.busy;
    assign m_rx    = on_b ? bus_b.rx_data : bus_a.rx_data;

    int total = 0;
    int bad   = 0;

    int           rises, ss_hi, done_cnt, ready_bad, mosi_bad;
    logic [F-1:0] stream, rx_at_done;
    logic         prev_sck, prev_mosi;

    typedef struct {
        logic [F-1:0] word;
        bit           sel_b;
        int           mm;
        bit           inject;
        int           exp_ss;
        int           exp_rises;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [F-1:0] rx_model(input logic [F-1:0] w, input int mm);
        if (!CAP) return '0;
        if (mm == 0) return w;
        if (mm == 1) return '1;
        return '0;
    endfunction

    task automatic drive(input logic v, input logic [F-1:0] d);
        if (on_b) begin
            bus_b.tx_valid = v;
            bus_b.tx_data  = d;
        end else begin
            bus_a.tx_valid = v;
            bus_a.tx_data  = d;
        end
    endtask

    task automatic clear_stats();
        rises = 0; ss_hi = 0; done_cnt = 0; ready_bad = 0; mosi_bad = 0;
        stream = '0; rx_at_done = '0;
        prev_sck = m_sck; prev_mosi = m_mosi;
    endtask

    // One clk of observation, taken at the falling edge.
    task automatic sample();
        @(negedge clk);
        if (m_sck && !prev_sck) begin
            rises++;
            stream = {stream[F-2:0], m_mosi};
        end
        if (m_sck && prev_sck && (m_mosi !== prev_mosi)) mosi_bad++;
        if (m_ss === 1'b1) begin
            ss_hi++;
            if (m_ready !== 1'b0 || m_busy !== 1'b1) ready_bad++;
        end
        if (m_done === 1'b1) begin
            done_cnt++;
            rx_at_done = m_rx;
        end
        prev_sck  = m_sck;
        prev_mosi = m_mosi;
    endtask

    task automatic send_frame(input vec_t v);
        int cyc;
        on_b = v.sel_b;
        miso_mode = v.mm;
        clear_stats();
        check({v.name, " ready_pre"}, 32'(m_ready), 32'd1);
        drive(1'b1, v.word);
        sample();
        drive(1'b0, ~v.word);
        cyc = 0;
        while (done_cnt == 0 && cyc < 600) begin
            if (v.inject && cyc == 8) drive(1'b1, 11'h0FF);
            else if (v.inject && cyc == 9) drive(1'b0, 11'h0FF);
            sample();
            cyc++;
        end
        for (int i = 0; i < GAP + 4; i++) sample();
        check({v.name, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({v.name, " ss_high"}, 32'(ss_hi), 32'(v.exp_ss));
        check({v.name, " sck_rises"}, 32'(rises), 32'(v.exp_rises));
        check({v.name, " mosi_stream"}, 32'(stream), 32'(v.word));
        check({v.name, " rx_data"}, 32'(rx_at_done), 32'(rx_model(v.word, v.mm)));
        check({v.name, " ready_busy"}, 32'(ready_bad), 32'd0);
        check({v.name, " mosi_stable"}, 32'(mosi_bad), 32'd0);
        $display("frame %s word=%h div=%0d ss_hi=%0d rises=%0d stream=%h rx=%h",
                 v.name, v.word, v.sel_b ? 1 : 2, ss_hi, rises, stream, rx_at_done);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         v;
        logic [F-1:0] s0;
        int           low_run, min_gap, cyc;

        bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
        bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state of both instances.
        check("rst sck",  32'({sck_a, sck_b}), 32'd0);
        check("rst ss",   32'({ss_a, ss_b}), 32'd0);
        check("rst mosi", 32'({mosi_a, mosi_b}), 32'd0);
        check("rst ready", 32'({bus_a.tx_ready, bus_b.tx_ready}), 32'd3);
        check("rst busy_done", 32'({bus_a.busy, bus_b.busy, bus_a.tx_done, bus_b.tx_done}), 32'd0);
        check("rst rx", 32'(bus_a.rx_data), 32'd0);

        // Directed table, then randomized records with model-computed expectations.
        vecs.push_back('{11'h5A3, 1'b0, 2, 1'b0, 46, F, "t1"});
        vecs.push_back('{11'h555, 1'b0, 2, 1'b1, 46, F, "t3"});
        vecs.push_back('{11'h2C9, 1'b0, 0, 1'b0, 46, F, "t5_loop"});
        vecs.push_back('{11'h123, 1'b0, 1, 1'b0, 46, F, "t5_ones"});
        vecs.push_back('{11'h7FF, 1'b1, 2, 1'b0, 23, F, "t6"});
        for (int i = 0; i < 8; i++) begin
            v.word      = F'($urandom);
            v.sel_b     = 1'($urandom_range(0, 1));
            v.mm        = int'($urandom_range(0, 2));
            v.inject    = 1'($urandom_range(0, 1));
            v.exp_ss    = (2 * F + 1) * (v.sel_b ? 1 : 2);
            v.exp_rises = F;
            v.name      = $sformatf("rnd%0d", i);
            vecs.push_back(v);
        end
        foreach (vecs[i]) send_frame(vecs[i]);

        // T2: tx_valid held across two frames.
        on_b = 1'b0;
        miso_mode = 2;
        clear_stats();
        drive(1'b1, 11'h001);
        s0 = '0; low_run = 0; min_gap = 999; cyc = 0;
        while (done_cnt < 2 && cyc < 600) begin
            sample();
            if (m_ss === 1'b1) begin
                if (done_cnt >= 1 && low_run > 0 && low_run < min_gap) min_gap = low_run;
                low_run = 0;
                drive(1'b1, 11'h7FE);
            end else begin
                low_run++;
            end
            if (done_cnt == 1 && s0 == '0) s0 = stream;
            cyc++;
        end
        drive(1'b0, 11'h7FE);
        for (int i = 0; i < GAP + 6; i++) sample();
        check("t2 frames", 32'(done_cnt), 32'd2);
        check("t2 first_stream", 32'(s0), 32'h001);
        check("t2 second_stream", 32'(stream), 32'h7FE);
        check("t2 gap_ok", 32'(min_gap >= GAP + 1), 32'd1);
        check("t2 ss_high", 32'(ss_hi), 32'(2 * (2 * F + 1) * 2));
        $display("frame t2 first=%h second=%h min_gap=%0d", s0, stream, min_gap);

        // T4: asynchronous reset after the 5th sck rise.
        on_b = 1'b0;
        clear_stats();
        drive(1'b1, 11'h6B4);
        sample();
        drive(1'b0, 11'h000);
        cyc = 0;
        while (rises < 5 && cyc < 200) begin
            sample();
            cyc++;
        end
        check("t4 reached_5_rises", 32'(rises), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t4 async_pins", 32'({sck_a, ss_a, mosi_a}), 32'd0);
        check("t4 async_ready", 32'(bus_a.tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        sample();
        check("t4 ready_after", 32'(m_ready), 32'd1);
        for (int i = 0; i < 6; i++) sample();
        check("t4 no_done", 32'(done_cnt), 32'd0);
        check("t4 ss_low", 32'(ss_hi), 32'd0);
        $display("frame t4 aborted after 5 rises, done=%0d", done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
